// File: rtl/dmem_responder.sv
// Data-memory responder: single-cycle stores, fixed-latency formatted loads with a busy stall.
// Optional misalignment trapping and the err port are enabled by defining DMEM_MISALIGN_TRAP_EN.
module dmem_responder #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned RD_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        funct3,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy
`ifdef DMEM_MISALIGN_TRAP_EN
  ,
  output logic              err
`endif
);

  localparam int unsigned Words = 2 ** (ADDR_W - 2);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e              state_q;
  logic [3:0]          cnt_q;
  logic [DATA_W-1:0]   hold_q;
  logic [1:0]          lo_q;
  logic [2:0]          f3_q;
  logic [DATA_W-1:0]   mem [Words];
  logic [ADDR_W-3:0]   widx;
  logic [3:0]          be;
  logic [DATA_W-1:0]   wdata;

  assign widx = addr[ADDR_W-1:2];

  function automatic logic [DATA_W-1:0] fmt_load(input logic [DATA_W-1:0] w,
                                                 input logic [1:0] lo, input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    case (lo)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = lo[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return w;
    endcase
  endfunction

`ifdef DMEM_MISALIGN_TRAP_EN
  logic st_mis;
  logic ld_mis;

  always_comb begin
    st_mis = 1'b0;
    case (funct3)
      3'b000:  st_mis = 1'b0;
      3'b001:  st_mis = addr[0];
      default: st_mis = (addr[1:0] != 2'b00);
    endcase
  end

  always_comb begin
    ld_mis = 1'b0;
    case (f3_q)
      3'b000, 3'b100: ld_mis = 1'b0;
      3'b001, 3'b101: ld_mis = lo_q[0];
      default:        ld_mis = (lo_q != 2'b00);
    endcase
  end
`endif

  // Lane enables and lane-replicated write data; unknown store codes act as sw.
  always_comb begin
    be    = 4'hf;
    wdata = wr_data;
    case (funct3)
      3'b000: begin
        be    = 4'b0001 << addr[1:0];
        wdata = {4{wr_data[7:0]}};
      end
      3'b001: begin
        be    = addr[1] ? 4'b1100 : 4'b0011;
        wdata = {2{wr_data[15:0]}};
      end
      default: begin
        be    = 4'hf;
        wdata = wr_data;
      end
    endcase
`ifdef DMEM_MISALIGN_TRAP_EN
    if (st_mis) be = 4'h0;
`endif
  end

  // Array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (reset && state_q == StIdle && wr) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[widx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      hold_q   <= '0;
      lo_q     <= 2'd0;
      f3_q     <= 3'd0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      busy     <= 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
      err      <= 1'b0;
`endif
    end else begin
      rd_valid <= 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
      err      <= 1'b0;
`endif
      case (state_q)
        StIdle: begin
          if (wr) begin
`ifdef DMEM_MISALIGN_TRAP_EN
            err <= st_mis;
`endif
          end else if (rd) begin
            hold_q <= mem[widx];
            lo_q   <= addr[1:0];
            f3_q   <= funct3;
            busy   <= 1'b1;
            if (RD_LAT == 1) begin
              state_q <= StResp;
            end else begin
              state_q <= StWait;
              cnt_q   <= 4'(RD_LAT - 2);
            end
          end
        end
        StWait: begin
          if (cnt_q == 4'd0) state_q <= StResp;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        StResp: begin
          rd_valid <= 1'b1;
          busy     <= 1'b0;
          state_q  <= StIdle;
`ifdef DMEM_MISALIGN_TRAP_EN
          rd_data  <= ld_mis ? '0 : fmt_load(hold_q, lo_q, f3_q);
          err      <= ld_mis;
`else
          rd_data  <= fmt_load(hold_q, lo_q, f3_q);
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed vector table, corner sequences and a
// randomized phase checked against a byte-array reference model.
module tb_dmem_responder;
  localparam int unsigned RdLat = 2;

  logic        clk = 1'b0;
  logic        reset, rd, wr;
  logic [8:0]  addr;
  logic [2:0]  funct3;
  logic [31:0] wr_data, rd_data;
  logic        rd_valid, busy;
`ifdef DMEM_MISALIGN_TRAP_EN
  logic        err;
`endif

  dmem_responder #(.DATA_W(32), .ADDR_W(9), .RD_LAT(RdLat)) dut (
    .clk     (clk),
    .reset   (reset),
    .rd      (rd),
    .wr      (wr),
    .addr    (addr),
    .funct3  (funct3),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .rd_valid(rd_valid),
    .busy    (busy)
`ifdef DMEM_MISALIGN_TRAP_EN
    ,
    .err     (err)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [7:0] model [512];

  typedef struct {
    string       name;
    bit          is_store;
    logic [8:0]  a;
    logic [2:0]  f3;
    logic [31:0] d;
    logic [31:0] exp;
    bit          exp_err;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic bit model_mis(input logic [8:0] a, input logic [2:0] f3, input bit is_store);
`ifdef DMEM_MISALIGN_TRAP_EN
    if (f3 == 3'd0 || (!is_store && f3 == 3'd4)) return 1'b0;
    if (f3 == 3'd1 || (!is_store && f3 == 3'd5)) return a[0];
    return a[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  function automatic void model_store(input logic [8:0] a, input logic [2:0] f3,
                                      input logic [31:0] d);
    int base = int'(a) & ~3;
    int hb = base + (a[1] ? 2 : 0);
    if (model_mis(a, f3, 1'b1)) return;
    case (f3)
      3'd0: model[a] = d[7:0];
      3'd1: begin
        model[hb]     = d[7:0];
        model[hb + 1] = d[15:8];
      end
      default: for (int i = 0; i < 4; i++) model[base + i] = d[8*i +: 8];
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [8:0] a, input logic [2:0] f3);
    int base = int'(a) & ~3;
    int hb = base + (a[1] ? 2 : 0);
    logic [7:0]  b = model[a];
    logic [15:0] h = {model[hb + 1], model[hb]};
    if (model_mis(a, f3, 1'b0)) return 32'd0;
    case (f3)
      3'd0: return {{24{b[7]}}, b};
      3'd1: return {{16{h[15]}}, h};
      3'd4: return {24'd0, b};
      3'd5: return {16'd0, h};
      default: return {model[base + 3], model[base + 2], model[base + 1], model[base]};
    endcase
  endfunction

  task automatic do_store(input logic [8:0] a, input logic [2:0] f3, input logic [31:0] d,
                          input bit also_rd);
    @(negedge clk);
    wr = 1'b1; rd = also_rd; addr = a; funct3 = f3; wr_data = d;
    @(negedge clk);
    wr = 1'b0; rd = 1'b0;
    check("store_idle_flags", {30'd0, rd_valid, busy}, 32'd0);
`ifdef DMEM_MISALIGN_TRAP_EN
    check("store_err", {31'd0, err}, {31'd0, model_mis(a, f3, 1'b1)});
`endif
    model_store(a, f3, d);
  endtask

  task automatic do_load(input logic [8:0] a, input logic [2:0] f3,
                         output logic [31:0] data, output bit e);
    int n;
    int nbusy = 0;
    bit seen = 0;
    @(negedge clk);
    rd = 1'b1; wr = 1'b0; addr = a; funct3 = f3;
    for (n = 1; n <= 20; n++) begin
      @(negedge clk);
      rd = 1'b0;
      if (rd_valid) begin
        seen = 1'b1;
        break;
      end
      if (busy) nbusy++;
    end
    check("load_timeout", {31'd0, seen}, 32'd1);
    check("load_latency", n, RdLat + 1);
    check("load_busy_cycles", nbusy, RdLat);
    check("load_busy_at_valid", {31'd0, busy}, 32'd0);
    data = rd_data;
`ifdef DMEM_MISALIGN_TRAP_EN
    e = err;
`else
    e = 1'b0;
`endif
  endtask

  task automatic load_check(input string name, input logic [8:0] a, input logic [2:0] f3,
                            input logic [31:0] exp, input bit exp_err);
    logic [31:0] got;
    bit e;
    do_load(a, f3, got, e);
    check(name, got, exp);
`ifdef DMEM_MISALIGN_TRAP_EN
    check({name, "_err"}, {31'd0, e}, {31'd0, exp_err});
`endif
  endtask

  initial begin
    bit any_v;
    for (int i = 0; i < 512; i++) model[i] = 8'd0;

    vecs.push_back('{"sw_010", 1, 9'h010, 3'd2, 32'hDEADBEEF, 32'h0, 0});
    vecs.push_back('{"lw_010", 0, 9'h010, 3'd2, 32'h0, 32'hDEADBEEF, 0});
    vecs.push_back('{"sw_010_zero", 1, 9'h010, 3'd2, 32'h0, 32'h0, 0});
    vecs.push_back('{"sb_013", 1, 9'h013, 3'd0, 32'h00000080, 32'h0, 0});
    vecs.push_back('{"lb_013", 0, 9'h013, 3'd0, 32'h0, 32'hFFFFFF80, 0});
    vecs.push_back('{"lbu_013", 0, 9'h013, 3'd4, 32'h0, 32'h00000080, 0});
    vecs.push_back('{"lw_010_after_sb", 0, 9'h010, 3'd2, 32'h0, 32'h80000000, 0});
    vecs.push_back('{"sw_020_zero", 1, 9'h020, 3'd2, 32'h0, 32'h0, 0});
    vecs.push_back('{"sh_022", 1, 9'h022, 3'd1, 32'h1234ABCD, 32'h0, 0});
    vecs.push_back('{"lhu_022", 0, 9'h022, 3'd5, 32'h0, 32'h0000ABCD, 0});
    vecs.push_back('{"lh_020", 0, 9'h020, 3'd1, 32'h0, 32'h00000000, 0});
    vecs.push_back('{"lh_022", 0, 9'h022, 3'd1, 32'h0, 32'hFFFFABCD, 0});
    vecs.push_back('{"lw_020", 0, 9'h020, 3'd2, 32'h0, 32'hABCD0000, 0});
`ifdef DMEM_MISALIGN_TRAP_EN
    vecs.push_back('{"sw_011_mis", 1, 9'h011, 3'd2, 32'hFFFFFFFF, 32'h0, 0});
    vecs.push_back('{"lw_010_unchanged", 0, 9'h010, 3'd2, 32'h0, 32'h80000000, 0});
    vecs.push_back('{"lh_021_mis", 0, 9'h021, 3'd1, 32'h0, 32'h00000000, 1});
`else
    vecs.push_back('{"lw_011_aligned_down", 0, 9'h011, 3'd2, 32'h0, 32'h80000000, 0});
    vecs.push_back('{"lh_023_uses_a1", 0, 9'h023, 3'd1, 32'h0, 32'hFFFFABCD, 0});
`endif

    // Reset held with rd asserted.
    reset = 1'b0; rd = 1'b1; wr = 1'b0; addr = 9'h010; funct3 = 3'd2; wr_data = 32'd0;
    repeat (2) begin
      @(negedge clk);
      check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_rd_data", rd_data, 32'd0);
`ifdef DMEM_MISALIGN_TRAP_EN
      check("rst_err", {31'd0, err}, 32'd0);
`endif
    end
    reset = 1'b1; rd = 1'b0;
    any_v = 1'b0;
    repeat (4) begin
      @(negedge clk);
      any_v |= rd_valid | busy;
    end
    check("post_rst_quiet", {31'd0, any_v}, 32'd0);

    foreach (vecs[i]) begin
      if (vecs[i].is_store) do_store(vecs[i].a, vecs[i].f3, vecs[i].d, 1'b0);
      else load_check(vecs[i].name, vecs[i].a, vecs[i].f3, vecs[i].exp, vecs[i].exp_err);
    end

    // Store and load requests presented while busy are ignored.
    @(negedge clk);
    rd = 1'b1; addr = 9'h020; funct3 = 3'd2;
    @(negedge clk);
    wr = 1'b1; wr_data = 32'hFFFFFFFF; any_v = 1'b0;
    for (int n = 0; n < 20 && !any_v; n++) begin
      @(negedge clk);
      any_v = rd_valid;
    end
    wr = 1'b0; rd = 1'b0;
    check("busy_ign_valid", {31'd0, any_v}, 32'd1);
    check("busy_ign_data", rd_data, 32'hABCD0000);
    @(negedge clk);
    check("busy_ign_no_queue", {30'd0, rd_valid, busy}, 32'd0);
    load_check("busy_ign_array", 9'h020, 3'd2, 32'hABCD0000, 0);

    // Reset while the read is in WAIT aborts it.
    do_store(9'h040, 3'd2, 32'hCAFEF00D, 1'b0);
    @(negedge clk);
    rd = 1'b1; addr = 9'h040; funct3 = 3'd2;
    @(negedge clk);
    rd = 1'b0; reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("midrd_rst_flags", {30'd0, rd_valid, busy}, 32'd0);
    check("midrd_rst_data", rd_data, 32'd0);
    any_v = 1'b0;
    repeat (4) begin
      @(negedge clk);
      any_v |= rd_valid;
    end
    check("midrd_no_valid", {31'd0, any_v}, 32'd0);
    load_check("midrd_reload", 9'h040, 3'd2, 32'hCAFEF00D, 0);

    // rd and wr together: the store wins.
    do_store(9'h050, 3'd2, 32'h11223344, 1'b1);
    any_v = 1'b0;
    repeat (3) begin
      @(negedge clk);
      any_v |= rd_valid;
    end
    check("rdwr_no_valid", {31'd0, any_v}, 32'd0);
    load_check("rdwr_stored", 9'h050, 3'd2, 32'h11223344, 0);

    // Randomized phase over a small window against the model.
    for (int i = 0; i < 8; i++) do_store(9'(9'h100 + 4 * i), 3'd2, $urandom, 1'b0);
    for (int i = 0; i < 60; i++) begin
      logic [8:0] a;
      logic [2:0] f3;
      a  = 9'(9'h100 + $urandom_range(0, 31));
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) do_store(a, f3, $urandom, 1'b0);
      else load_check("rand_load", a, f3, model_load(a, f3), model_mis(a, f3, 1'b0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
